// File: rtl/fetch_decode_unit.sv
// Front-end sequencer for the 8-bit teaching CPU.
// This block owns the PC, drives the instruction ROM address and clear lines,
// and latches and decodes each instruction. ALU and load ops go to the execute
// stage over a valid/ready handshake. Jump and halt are handled internally.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ROM held in clear, PC parked at 0, waiting for start
// S_FETCH | one cycle: sample the ROM word into IR and resolve control ops
// S_ISSUE | decoded op presented to the execute stage until it is accepted
// S_HALT  | halted or overrun; waits for start to rerun from address 0
module fetch_decode_unit #(
    parameter int ADDR_W    = 8,
    parameter int ROM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        instruction,
    input  logic              ex_ready,
    output logic [ADDR_W-1:0] address,
    output logic              clear,
    output logic              dec_valid,
    output logic [1:0]        dec_op,
    output logic [1:0]        dec_rs,
    output logic [1:0]        dec_rt,
    output logic [1:0]        dec_rd,
    output logic              halted,
    output logic              overrun,
    output logic [7:0]        instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    // One extra bit so that a depth equal to 2^ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_L = ROM_DEPTH[ADDR_W:0];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;
    logic              is_ctrl;
    logic              is_halt;
    logic              in_range;
    logic [ADDR_W-1:0] jump_target;

    // Decode the live ROM word during FETCH, before it is captured in IR.
    always_comb begin
        is_ctrl     = (instruction[7:6] == 2'b11);
        is_halt     = is_ctrl && (instruction[5:0] == 6'b000011);
        in_range    = ({1'b0, pc} < DEPTH_L);
        jump_target = '0;
        jump_target[5:0] = instruction[5:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE and HALT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (!in_range)    state_nxt = S_HALT;
                else if (is_halt) state_nxt = S_HALT;
                else if (is_ctrl) state_nxt = S_FETCH;
                else              state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (ex_ready) state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (start) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // PC, IR, handshake and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            ir          <= '0;
            dec_valid   <= 1'b0;
            halted      <= 1'b0;
            overrun     <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc          <= '0;
                        halted      <= 1'b0;
                        overrun     <= 1'b0;
                        instr_count <= '0;
                    end
                end
                S_FETCH: begin
                    if (!in_range) begin
                        // Overrun leaves IR untouched: the word at this address is not real.
                        overrun <= 1'b1;
                    end else begin
                        ir <= instruction;
                        if (is_halt) begin
                            halted <= 1'b1;
                        end else if (is_ctrl) begin
                            pc <= jump_target;
                        end else begin
                            dec_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ex_ready) begin
                        dec_valid <= 1'b0;
                        pc        <= pc + 1'b1;
                        if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ROM interface and decoded fields come straight from PC, state and IR.
    always_comb begin
        address = pc;
        clear   = (state == S_IDLE);
        dec_op  = ir[7:6];
        dec_rs  = ir[5:4];
        dec_rt  = ir[3:2];
        dec_rd  = ir[1:0];
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: fibonacci program, backpressure,
// jump, restart from halt, mid-issue reset and ROM overrun.
module tb_fetch_decode_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ex_ready;
    logic [7:0] instruction;
    logic [7:0] address;
    logic       clear;
    logic       dec_valid;
    logic [1:0] dec_op, dec_rs, dec_rt, dec_rd;
    logic       halted, overrun;
    logic [7:0] instr_count;

    logic       start4;
    logic       ex_ready4;
    logic [7:0] instruction4;
    logic [7:0] address4;
    logic       clear4;
    logic       dec_valid4;
    logic [1:0] dec_op4, dec_rs4, dec_rt4, dec_rd4;
    logic       halted4, overrun4;
    logic [7:0] instr_count4;

    logic [7:0] rom [256];

    int errors = 0;
    int checks = 0;

    int         last_edge;
    logic [7:0] acc_addr [$];
    logic [7:0] acc_fld  [$];

    fetch_decode_unit #(.ADDR_W(8), .ROM_DEPTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
        .ex_ready(ex_ready), .address(address), .clear(clear),
        .dec_valid(dec_valid), .dec_op(dec_op), .dec_rs(dec_rs),
        .dec_rt(dec_rt), .dec_rd(dec_rd), .halted(halted),
        .overrun(overrun), .instr_count(instr_count)
    );

    fetch_decode_unit #(.ADDR_W(8), .ROM_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .instruction(instruction4),
        .ex_ready(ex_ready4), .address(address4), .clear(clear4),
        .dec_valid(dec_valid4), .dec_op(dec_op4), .dec_rs(dec_rs4),
        .dec_rt(dec_rt4), .dec_rd(dec_rd4), .halted(halted4),
        .overrun(overrun4), .instr_count(instr_count4)
    );

    assign instruction  = rom[address];
    assign instruction4 = 8'h27;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic load_fib;
        fill_rom(8'hC3);
        rom[0] = 8'h48; rom[1] = 8'h27; rom[2] = 8'h39; rom[3] = 8'h2C;
        rom[4] = 8'h07; rom[5] = 8'h32; rom[6] = 8'h2D; rom[7] = 8'h18;
        rom[8] = 8'hC3;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Run until halted/overrun, logging every accepted op and the edge it was accepted on.
    task automatic run_prog(input int budget);
        int e;
        e = 0;
        acc_addr.delete();
        acc_fld.delete();
        last_edge = -1;
        while (!(halted || overrun) && e < budget) begin
            if (dec_valid && ex_ready) begin
                acc_addr.push_back(address);
                acc_fld.push_back({dec_op, dec_rs, dec_rt, dec_rd});
                last_edge = e + 1;
            end
            tick;
            e++;
        end
        chk("run_terminates", 32'(halted || overrun), 1);
    endtask

    task automatic wait_issue_at(input logic [7:0] a, input string tag);
        int n;
        n = 0;
        while (!(dec_valid && address == a) && n < 60) begin
            tick;
            n++;
        end
        chk(tag, 32'(dec_valid && address == a), 1);
    endtask

    task automatic check_fib_final(input string pfx);
        chk({pfx, "_halted"},  32'(halted), 1);
        chk({pfx, "_overrun"}, 32'(overrun), 0);
        chk({pfx, "_address"}, 32'(address), 8);
        chk({pfx, "_count"},   32'(instr_count), 8);
        chk({pfx, "_valid"},   32'(dec_valid), 0);
    endtask

    initial begin
        int n4;
        rst_n     = 1'b0;
        start     = 1'b0;
        ex_ready  = 1'b1;
        start4    = 1'b0;
        ex_ready4 = 1'b1;
        load_fib();
        #12;

        chk("rst_clear",   32'(clear), 1);
        chk("rst_address", 32'(address), 0);
        chk("rst_valid",   32'(dec_valid), 0);
        chk("rst_halted",  32'(halted), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_count",   32'(instr_count), 0);
        rst_n = 1'b1;
        tick;
        tick;
        chk("idle_clear_hold", 32'(clear), 1);

        // Fibonacci program, no backpressure.
        pulse_start();
        chk("start_clear_drop", 32'(clear), 0);
        run_prog(100);
        chk("fib_issues",     32'(acc_fld.size()), 8);
        chk("fib_first_fld",  32'(acc_fld[0]), 32'h48);
        chk("fib_last_fld",   32'(acc_fld[7]), 32'h18);
        chk("fib_last_addr",  32'(acc_addr[7]), 7);
        chk("fib_last_edge",  32'(last_edge), 16);
        check_fib_final("fib");
        tick;
        tick;
        chk("halt_ignores_ready", 32'(dec_valid), 0);

        // Restart from HALT.
        pulse_start();
        chk("rs_halted", 32'(halted), 0);
        chk("rs_count",  32'(instr_count), 0);
        chk("rs_address", 32'(address), 0);
        run_prog(100);
        chk("rs_issues", 32'(acc_fld.size()), 8);
        chk("rs_last_edge", 32'(last_edge), 16);
        check_fib_final("rs");

        // Backpressure on the second issue, with a start pulse while stalled.
        pulse_start();
        wait_issue_at(8'd1, "bp_reach_issue1");
        ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) start = 1'b1;
            tick;
            start = 1'b0;
            chk("bp_valid", 32'(dec_valid), 1);
            chk("bp_fields", 32'({dec_op, dec_rs, dec_rt, dec_rd}), 32'h27);
            chk("bp_address", 32'(address), 1);
            chk("bp_count", 32'(instr_count), 1);
        end
        ex_ready = 1'b1;
        run_prog(100);
        chk("bp_first_after", 32'(acc_addr[0]), 1);
        chk("bp_issues_after", 32'(acc_fld.size()), 7);
        check_fib_final("bp");

        // Asynchronous reset while address 3 is being issued.
        pulse_start();
        wait_issue_at(8'd3, "rst_reach_issue3");
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   32'(dec_valid), 0);
        chk("mid_rst_clear",   32'(clear), 1);
        chk("mid_rst_address", 32'(address), 0);
        chk("mid_rst_count",   32'(instr_count), 0);
        #1 rst_n = 1'b1;
        tick;
        pulse_start();
        run_prog(100);
        chk("replay_first_addr", 32'(acc_addr[0]), 0);
        chk("replay_issues", 32'(acc_fld.size()), 8);
        check_fib_final("replay");

        // Jump program: 0 issue, 1 jumps to 5, 5 issues, 6 halts.
        fill_rom(8'hC3);
        rom[0] = 8'h27;
        rom[1] = 8'hC5;
        rom[5] = 8'h2D;
        rom[6] = 8'hC3;
        pulse_start();
        run_prog(100);
        chk("jmp_issues", 32'(acc_addr.size()), 2);
        chk("jmp_addr0",  32'(acc_addr[0]), 0);
        chk("jmp_addr1",  32'(acc_addr[1]), 5);
        chk("jmp_fld1",   32'(acc_fld[1]), 32'h2D);
        chk("jmp_count",  32'(instr_count), 2);
        chk("jmp_halted", 32'(halted), 1);
        chk("jmp_address", 32'(address), 6);

        // Overrun on the 4-word ROM instance.
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        n4 = 0;
        for (int c = 0; c < 40 && !overrun4; c++) begin
            if (dec_valid4) n4++;
            tick;
        end
        chk("ovr_issues",  32'(n4), 4);
        chk("ovr_overrun", 32'(overrun4), 1);
        chk("ovr_halted",  32'(halted4), 0);
        chk("ovr_address", 32'(address4), 4);
        chk("ovr_valid",   32'(dec_valid4), 0);
        chk("ovr_count",   32'(instr_count4), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
